sram_bank_arbiter: RTL
======================

// Module: sram_bank_arbiter
// PURPOSE
//  Shares one single-port sram_wrapper bank between NumReq OBI-style requesters.
//  - Arbitration: round-robin, one transaction per cycle.
//  - Routes the 1-cycle read response back to the owner of the transaction.
//  - Sequences the bank's power-gate and retention controls on a sleep/wake handshake.
//  - Sits between the bus demux and each sram_wrapper instance.
// PARAMETERS
//  NumReq    2     number of requesters (2..8)
//  NumWords  1024  bank depth in 32-bit words
//  AddrWidth $clog2(NumWords) (1 if NumWords<=1); derived, do not override
// PORTS
//  clk_i                1   in   clock
//  rst_i                1   in   synchronous reset, active-high
//  req_i                NumReq           in   per-requester request
//  we_i                 NumReq           in   1=write, 0=read
//  addr_i               NumReq*AddrWidth in   word address, packed, requester 0 in LSBs
//  wdata_i              NumReq*32        in   write data, packed
//  be_i                 NumReq*4         in   byte enables, packed
//  gnt_o                NumReq           out  grant (combinational), one-hot or zero
//  rvalid_o             NumReq           out  response valid, one-hot or zero
//  rdata_o              32               out  response data (broadcast)
//  sram_req_o           1    out  to sram_wrapper req_i
//  sram_we_o            1    out  to sram_wrapper we_i
//  sram_addr_o          AddrWidth  out  to sram_wrapper addr_i
//  sram_wdata_o         32   out  to sram_wrapper wdata_i
//  sram_be_o            4    out  to sram_wrapper be_i
//  sram_rdata_i         32   in   from sram_wrapper rdata_o
//  sleep_req_i          1    in   1=put bank to sleep, 0=wake; level, held until sleep_ack_o matches
//  retentive_i          1    in   sampled with sleep_req_i rise: 1=retention, 0=power-off
//  sleep_ack_o          1    out  1=bank asleep, 0=bank active
//  sram_pwrgate_no      1    out  to sram_wrapper pwrgate_ni (0=gated)
//  sram_pwrgate_ack_ni  1    in   from sram_wrapper pwrgate_ack_no
//  sram_set_retentive_no 1   out  to sram_wrapper set_retentive_ni (0=retain)
// BEHAVIOUR
//  FSM: ACTIVE, RET, PD_WAIT, OFF, PU_WAIT.
//  Power-control outputs and sleep_ack_o are registered.
//  Reset:
//  - state=ACTIVE, rr pointer=0, rvalid_o=0, rdata mux owner=0.
//  - sram_pwrgate_no=1, sram_set_retentive_no=1, sleep_ack_o=0.
//  - Reset in any state, mid-transaction or gated, forces these values at the next edge.
//  - An in-flight rvalid is dropped.
//  Arbitration (ACTIVE and sleep_req_i=0 only; otherwise gnt_o=0, sram_req_o=0):
//  - Winner = first i with req_i[i] set, scanning ptr, ptr+1, ... wrapping modulo NumReq.
//  - gnt_o[winner]=1 in the same cycle.
//  - sram_* driven from the winner's fields; sram_req_o=|gnt_o.
//  - Idle sram_* data/addr = 0.
//  - After a grant, ptr <= winner+1 (mod NumReq). With no grant, ptr is held.
//  Response:
//  - Every granted transaction (read or write) gives rvalid_o[winner]=1 exactly 1 cycle later.
//  - rdata_o=sram_rdata_i while any rvalid_o is set, else 0. Write responses carry no meaningful data.
//  - Back-to-back grants give back-to-back rvalids. No backpressure; requesters must accept rvalid.
//  Sleep (from ACTIVE when sleep_req_i=1; grants blocked that same cycle):
//  - retentive_i=1 -> RET.
//    - sram_set_retentive_no=0, sleep_ack_o=1 on entry.
//  - retentive_i=0 -> PD_WAIT.
//    - sram_pwrgate_no=0; wait for sram_pwrgate_ack_ni=0.
//    - Then OFF with sleep_ack_o=1.
//  - The rvalid of a grant issued the cycle before the sleep request is still delivered.
//    The SRAM read completes at that edge.
//  Wake:
//  - RET & sleep_req_i=0 -> ACTIVE next cycle.
//    - sram_set_retentive_no=1, sleep_ack_o=0.
//  - OFF & sleep_req_i=0 -> PU_WAIT.
//    - sram_pwrgate_no=1; wait for sram_pwrgate_ack_ni=1.
//    - Then ACTIVE with sleep_ack_o=0. Memory contents undefined after power-off.
//  - sleep_req_i changes in PD_WAIT/PU_WAIT are ignored until the wait completes.
//  - Requests during non-ACTIVE states stay pending, never granted; ptr is held.
// TESTING
//  1 Reset, req_i=2'b11, both reads, held 4 cycles:
//    - gnt 01,10,01,10; rvalid follows each grant by 1 cycle.
//    - rdata matches prior writes.
//  2 Req0 writes 0xDEADBEEF to addr 5 with be=4'b0011, then reads addr 5:
//    - rvalid_o[0] on both; read rdata=0x0000BEEF, given a prior write of 0 to addr 5.
//  3 NumReq=4, ptr=3, req_i=4'b0101 -> gnt 0001 then 0100; req_i=0 cycle -> gnt 0, ptr held.
//  4 Read granted at t, sleep_req_i=1 (retentive_i=1) at t+1:
//    - rvalid at t+1 with valid data; set_retentive_no=0 and sleep_ack_o=1 at t+2.
//    - Pending req not granted; wake -> ACTIVE and grant resumes.
//  5 sleep_req_i=1, retentive_i=0; pwrgate_ack_ni drops 3 cycles after pwrgate_no=0:
//    - sleep_ack_o=1 exactly 1 cycle after ack.
//    - Wake mirrors this, with ack rising 5 cycles later.
//  6 rst_i asserted in OFF and during a pending rvalid:
//    - Next cycle pwrgate_no=1, set_retentive_no=1, sleep_ack_o=0, rvalid_o=0, gnt from requester 0.

Source files
------------

// File: rtl/sram_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank_arbiter
// Description : Round-robin sharing of one single-port SRAM bank between
//               NumReq requesters, with sleep/retention/power-gate sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bank_arbiter #(
    parameter int  NumReq    = 2,
    parameter int  NumWords  = 1024,
    localparam int AddrWidth = (NumWords <= 1) ? 1 : $clog2(NumWords)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_i,
    input  logic [NumReq-1:0]           we_i,
    input  logic [NumReq*AddrWidth-1:0] addr_i,
    input  logic [NumReq*32-1:0]        wdata_i,
    input  logic [NumReq*4-1:0]         be_i,
    output logic [NumReq-1:0]           gnt_o,
    output logic [NumReq-1:0]           rvalid_o,
    output logic [31:0]                 rdata_o,
    output logic                        sram_req_o,
    output logic                        sram_we_o,
    output logic [AddrWidth-1:0]        sram_addr_o,
    output logic [31:0]                 sram_wdata_o,
    output logic [3:0]                  sram_be_o,
    input  logic [31:0]                 sram_rdata_i,
    input  logic                        sleep_req_i,
    input  logic                        retentive_i,
    output logic                        sleep_ack_o,
    output logic                        sram_pwrgate_no,
    input  logic                        sram_pwrgate_ack_ni,
    output logic                        sram_set_retentive_no
);

    localparam int c_ptr_width = (NumReq <= 1) ? 1 : $clog2(NumReq);

    typedef enum logic [2:0] {
        ST_ACTIVE  = 3'd0,
        ST_RET     = 3'd1,
        ST_PD_WAIT = 3'd2,
        ST_OFF     = 3'd3,
        ST_PU_WAIT = 3'd4
    } state_t;

    state_t                 r_state;
    logic [c_ptr_width-1:0] r_ptr;
    logic [NumReq-1:0]      r_rvalid;
    logic                   r_sleep_ack;
    logic                   r_pwrgate_n;
    logic                   r_set_retentive_n;

    logic [c_ptr_width-1:0] w_win;
    logic [c_ptr_width-1:0] w_ptr_next;
    logic                   w_found;
    logic                   w_arb_en;
    logic                   w_grant;
    logic [NumReq-1:0]      w_gnt;
    int                     w_idx;

    // Scan requesters starting at the round-robin pointer; first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < NumReq; k++) begin
            w_idx = (int'(r_ptr) + k) % NumReq;
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = c_ptr_width'(w_idx);
            end
        end
    end

    assign w_arb_en   = (r_state == ST_ACTIVE) && !sleep_req_i;
    assign w_grant    = w_arb_en && w_found;
    assign w_ptr_next = (w_win == c_ptr_width'(NumReq - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_gnt = '0;
        if (w_grant) begin
            w_gnt[w_win] = 1'b1;
        end
    end

    assign gnt_o        = w_gnt;
    assign sram_req_o   = w_grant;
    assign sram_we_o    = w_grant & we_i[w_win];
    assign sram_addr_o  = w_grant ? addr_i[int'(w_win)*AddrWidth +: AddrWidth] : '0;
    assign sram_wdata_o = w_grant ? wdata_i[int'(w_win)*32 +: 32] : '0;
    assign sram_be_o    = w_grant ? be_i[int'(w_win)*4 +: 4] : '0;

    // The bank returns read data one cycle after the grant, aligned with rvalid.
    assign rvalid_o = r_rvalid;
    assign rdata_o  = (|r_rvalid) ? sram_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr    <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_grant) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state           <= ST_ACTIVE;
            r_sleep_ack       <= 1'b0;
            r_pwrgate_n       <= 1'b1;
            r_set_retentive_n <= 1'b1;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    if (sleep_req_i) begin
                        if (retentive_i) begin
                            r_state           <= ST_RET;
                            r_set_retentive_n <= 1'b0;
                            r_sleep_ack       <= 1'b1;
                        end else begin
                            r_state     <= ST_PD_WAIT;
                            r_pwrgate_n <= 1'b0;
                        end
                    end
                end
                ST_RET: begin
                    if (!sleep_req_i) begin
                        r_state           <= ST_ACTIVE;
                        r_set_retentive_n <= 1'b1;
                        r_sleep_ack       <= 1'b0;
                    end
                end
                ST_PD_WAIT: begin
                    if (!sram_pwrgate_ack_ni) begin
                        r_state     <= ST_OFF;
                        r_sleep_ack <= 1'b1;
                    end
                end
                ST_OFF: begin
                    if (!sleep_req_i) begin
                        r_state     <= ST_PU_WAIT;
                        r_pwrgate_n <= 1'b1;
                    end
                end
                ST_PU_WAIT: begin
                    if (sram_pwrgate_ack_ni) begin
                        r_state     <= ST_ACTIVE;
                        r_sleep_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state           <= ST_ACTIVE;
                    r_sleep_ack       <= 1'b0;
                    r_pwrgate_n       <= 1'b1;
                    r_set_retentive_n <= 1'b1;
                end
            endcase
        end
    end

    assign sleep_ack_o           = r_sleep_ack;
    assign sram_pwrgate_no       = r_pwrgate_n;
    assign sram_set_retentive_no = r_set_retentive_n;

endmodule
`default_nettype wire
